// File: rtl/riscv_pkg.sv
// riscv_pkg: multicycle controller state type, opcode constants and ALU encodings shared with the ALU.
package riscv_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
    } state_t;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction fields and ALU flag into the controller, datapath enables/selects out.
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus funct3/funct7b5 to the ALU control encoding.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);
    always_comb begin
        alu_control_o = ALU_ADD;
        if (alu_op_i == ALUOP_SUB) alu_control_o = ALU_SUB;
        else if (alu_op_i == ALUOP_FUNCT)
            case (funct3_i)
                // op[5] separates R-type sub from addi, whose imm bit 30 is data
                3'b000:  alu_control_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_control_o = ALU_SLL;
                3'b010:  alu_control_o = ALU_SLT;
                3'b110:  alu_control_o = ALU_OR;
                3'b111:  alu_control_o = ALU_AND;
                default: alu_control_o = ALU_ADD;
            endcase
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control FSM with ImmSrc decode; ALU control comes from alu_decoder.
module mc_controller
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    mc_controller_if.master bus
);
    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch, ir_write, mem_write, reg_write;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= S_FETCH;
        else state_q <= state_d;
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = (bus.op == OP_LOAD || bus.op == OP_STORE) ? S_MEMADR :
                                 bus.op == OP_RTYPE  ? S_EXECUTER :
                                 bus.op == OP_ITYPE  ? S_EXECUTEI :
                                 bus.op == OP_BRANCH ? S_BEQ :
                                 bus.op == OP_JAL    ? S_JAL : S_FETCH;
            S_MEMADR:  state_d = bus.op == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end
    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_op        = ALUOP_ADD;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write      = 1'b1;
                pc_update     = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMREAD: bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_write     = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = ALUOP_SUB;
                branch      = 1'b1;
            end
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
            end
            default: ;
        endcase
    end
    // state is forced to FETCH during reset, so write enables are gated to keep them quiet
    assign bus.PCWrite  = reset_n & (pc_update | (branch & bus.Zero));
    assign bus.IRWrite  = reset_n & ir_write;
    assign bus.MemWrite = reset_n & mem_write;
    assign bus.RegWrite = reset_n & reg_write;
    assign bus.ImmSrc   = bus.op == OP_STORE  ? 2'b01 :
                          bus.op == OP_BRANCH ? 2'b10 :
                          bus.op == OP_JAL    ? 2'b11 : 2'b00;
    alu_decoder u_alu_decoder (
        .alu_op_i     (alu_op),
        .funct3_i     (bus.funct3),
        .funct7b5_i   (bus.funct7b5),
        .op5_i        (bus.op[5]),
        .alu_control_o(bus.ALUControl)
    );
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all other ports are listed below.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 op  in  7  opcode field from the external instruction register.
REQ-005 funct3  in  3  instruction bits 14:12.
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 Zero  in  1  ALU zero flag, valid in the same cycle.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath mux selects.
REQ-010 ALUControl  out  3  ALU encoding: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt.

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-012 All outputs SHALL be combinational from state, op, funct3, funct7b5 and Zero, with zero latency.
REQ-013 Any enable or select not listed for a state SHALL be 0 in that state.
REQ-014 FETCH SHALL drive IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; next state is DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state depends on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other op -> FETCH (treated as a NOP; PC has already advanced).
REQ-016 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state is MEMREAD if op=0000011, else MEMWRITE.
REQ-017 MEMREAD SHALL drive ResultSrc=00, AdrSrc=1; next state is MEMWB.
REQ-018 MEMWB SHALL drive ResultSrc=01, RegWrite=1; next state is FETCH.
REQ-019 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1, MemWrite=1; next state is FETCH.
REQ-020 EXECUTER SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state is ALUWB.
REQ-021 EXECUTEI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; next state is ALUWB.
REQ-022 ALUWB SHALL drive ResultSrc=00, RegWrite=1; next state is FETCH.
REQ-023 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; next state is FETCH.
REQ-024 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; next state is ALUWB.
REQ-025 PCWrite SHALL equal PCUpdate OR (Branch AND Zero); Zero is ignored outside BEQ.
REQ-026 ImmSrc SHALL decode op in every state:
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- all other op -> 00.
REQ-027 ALUControl decode:
- ALUOp=00 -> 000
- ALUOp=01 -> 001
- ALUOp=10, decode by funct3:
  - 000 -> 001 if (funct7b5 AND op[5]), else 000
  - 001 -> 100
  - 010 -> 101
  - 110 -> 011
  - 111 -> 010
  - any other funct3 -> 000.
REQ-028 For addi, funct7b5=1 SHALL NOT select sub, because op[5]=0.

Reset
REQ-029 Asserting reset_n=0 SHALL force the state to FETCH immediately, regardless of clk, including mid-instruction.
REQ-030 While reset_n=0, PCWrite, MemWrite, IRWrite and RegWrite SHALL be 0.
REQ-031 On the first rising clk edge after reset_n rises, the block SHALL perform a FETCH; after that the next state is DECODE.

Structure
REQ-032 Package riscv_pkg SHALL hold:
- the state enum type
- opcode constants
- the ALUOp encodings
- the ALUControl encodings, shared with the existing ALU.
REQ-033 The ALUOp/funct to ALUControl decode SHALL be a sub-module named alu_decoder; the FSM and ImmSrc decode SHALL stay in mc_controller.

Verification
REQ-034 lw (op=0000011) from reset: states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, then FETCH; RegWrite=1 only in MEMWB, with ResultSrc=01 there.
REQ-035 sw (op=0100011): MemWrite=1 for exactly one cycle in MEMWRITE with AdrSrc=1; ImmSrc=01 throughout; the instruction takes 4 cycles.
REQ-036 R-type sub (funct3=000, funct7b5=1): ALUControl=001 in EXECUTER; with funct7b5=0, ALUControl=000; addi with funct7b5=1 gives 000.
REQ-037 slli (op=0010011, funct3=001) -> ALUControl=100; slt (op=0110011, funct3=010) -> ALUControl=101.
REQ-038 beq: Zero=1 in BEQ -> PCWrite=1; Zero=0 -> PCWrite=0. jal: path is FETCH, DECODE, JAL, ALUWB, FETCH, with PCWrite=1 in JAL.
REQ-039 Unknown op=1111111 -> DECODE then FETCH with no writes; reset_n pulsed low in MEMREAD -> state is FETCH immediately and all enables are 0 while low.
